// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   Multi-cycle adder/subtractor. It processes DIGIT bits per clock through one
//   DIGIT-bit ripple chain, so a WIDTH-bit result takes N = WIDTH/DIGIT RUN cycles.
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request an operation (accepted in IDLE or DONE)
//   sub    : 0 = add, 1 = subtract (sampled with start)
//   a, b   : operands (sampled with start)
//   cin    : carry-in for add, ignored for subtract (sampled with start)
//   busy   : digits are being processed
//   done   : one-cycle pulse, sum/cout/ovf valid
//   sum    : result, held from done until the next accepted start
//   cout   : carry out of bit WIDTH-1 (subtract: 1 = no borrow)
//   ovf    : signed overflow
module digit_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("digit_serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0]       dig_sum;
    logic                   dig_carry;
    logic                   dig_msb_cin;
    logic                   rip_c;
    logic [WIDTH+DIGIT-1:0] sum_shift;

    // The operand registers shift right by one digit per RUN cycle, so the
    // current digit k always sits in the low DIGIT bits. This avoids a
    // WIDTH-wide digit-select mux on each operand.
    always_comb begin
        rip_c       = carry_q;
        dig_msb_cin = carry_q;
        dig_sum     = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            dig_msb_cin = rip_c;
            dig_sum[i]  = a_q[i] ^ b_q[i] ^ rip_c;
            rip_c       = (a_q[i] & b_q[i]) | (rip_c & (a_q[i] ^ b_q[i]));
        end
        dig_carry = rip_c;
    end

    // Result digits enter at the top and move down; after N cycles digit k
    // has landed in bits k*DIGIT +: DIGIT.
    assign sum_shift = {dig_sum, sum_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub | cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = sum_shift[WIDTH+DIGIT-1:DIGIT];
                carry_d = dig_carry;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d  = dig_carry;
                    // carry into the MSB of the last digit is the carry into bit WIDTH-1
                    ovf_d   = dig_carry ^ dig_msb_cin;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: directed vectors on a 16/4
// instance, plus a 1000-vector sweep on 16/1 and 16/16 instances.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub, cin;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    logic        s_start, s_sub, s_cin;
    logic [15:0] s_a, s_b;
    logic        d1_busy, d1_done, d1_cout, d1_ovf;
    logic [15:0] d1_sum;
    logic        d16_busy, d16_done, d16_cout, d16_ovf;
    logic [15:0] d16_sum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b), .cin(s_cin),
        .busy(d1_busy), .done(d1_done), .sum(d1_sum), .cout(d1_cout), .ovf(d1_ovf)
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut_d16 (
        .clk(clk), .rst(rst), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b), .cin(s_cin),
        .busy(d16_busy), .done(d16_done), .sum(d16_sum), .cout(d16_cout), .ovf(d16_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation on the 16/4 instance with exact handshake timing.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tsub, input logic tcin, input logic [15:0] esum,
                         input logic ecout, input logic eovf);
        a = ta; b = tb_v; sub = tsub; cin = tcin; start = 1'b1;
        step();
        start = 1'b0;
        a = 16'hdead; b = 16'hbeef; sub = ~tsub; cin = ~tcin;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_run"}, {30'd0, busy, done}, 32'd2);
            step();
        end
        check({tag, "_done"}, {30'd0, busy, done}, 32'd1);
        check({tag, "_res"}, {14'd0, cout, ovf, sum}, {14'd0, ecout, eovf, esum});
        step();
        check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    logic [15:0] ops_a [5] = '{16'h0001, 16'h0100, 16'h0010, 16'h1000, 16'h0000};
    logic [15:0] ops_b [5] = '{16'h0002, 16'h0200, 16'h0020, 16'h2000, 16'h0000};
    logic [15:0] ops_e [4] = '{16'h0003, 16'h0300, 16'h0030, 16'h3000};

    logic [15:0] r_bb;
    logic [16:0] r_full;
    logic        r_ovf;

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        s_start = 1'b0; s_sub = 1'b0; s_cin = 1'b0; s_a = '0; s_b = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_ctl", {30'd0, busy, done}, 32'd0);
        check("reset_res", {14'd0, cout, ovf, sum}, 32'd0);

        do_op("add_cin", 16'h1234, 16'h0fcd, 1'b0, 1'b1, 16'h2202, 1'b0, 1'b0);
        do_op("add_wrap", 16'hffff, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_ovf", 16'h7fff, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hfffe, 1'b0, 1'b0);

        // start pulsed in the 2nd RUN cycle must be ignored
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 16'hffff; b = 16'hffff; sub = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("ign_done", {30'd0, busy, done}, 32'd1);
        check("ign_res", {14'd0, cout, ovf, sum}, {16'd0, 16'h3333});
        step();
        check("ign_noqueue", {30'd0, busy, done}, 32'd0);

        // start held high: one result every 5 cycles
        sub = 1'b0; cin = 1'b0; a = ops_a[0]; b = ops_b[0]; start = 1'b1;
        step();
        for (int r = 0; r < 4; r++) begin
            a = ops_a[r+1]; b = ops_b[r+1];
            if (r == 3) start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                check("b2b_run", {30'd0, busy, done}, 32'd2);
                step();
            end
            check("b2b_done", {30'd0, busy, done}, 32'd1);
            check("b2b_res", {16'd0, sum}, {16'd0, ops_e[r]});
            step();
        end
        check("b2b_end", {30'd0, busy, done}, 32'd0);

        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7fff, 1'b1, 1'b1);

        // reset in the 2nd RUN cycle aborts; cout/ovf were 1 from the last op
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_ctl", {30'd0, busy, done}, 32'd0);
        check("rst_res", {14'd0, cout, ovf, sum}, 32'd0);
        step();
        check("rst_stay", {30'd0, busy, done}, 32'd0);
        do_op("after_rst", 16'h00ff, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Sweep on DIGIT=1 and DIGIT=16 instances started together
        for (int v = 0; v < 1000; v++) begin
            s_a   = 16'($urandom);
            s_b   = 16'($urandom);
            s_sub = 1'($urandom);
            s_cin = 1'($urandom);
            r_bb   = s_sub ? ~s_b : s_b;
            r_full = {1'b0, s_a} + {1'b0, r_bb} + {16'd0, (s_sub ? 1'b1 : s_cin)};
            r_ovf  = (s_a[15] == r_bb[15]) && (r_full[15] != s_a[15]);
            s_start = 1'b1;
            step();
            s_start = 1'b0;
            for (int c = 1; c <= 16; c++) begin
                step();
                if (c == 1) begin
                    check("d16_done", {31'd0, d16_done}, 32'd1);
                    check("d16_res", {14'd0, d16_cout, d16_ovf, d16_sum},
                          {14'd0, r_full[16], r_ovf, r_full[15:0]});
                end
                if (c == 16) begin
                    check("d1_done", {31'd0, d1_done}, 32'd1);
                    check("d1_res", {14'd0, d1_cout, d1_ovf, d1_sum},
                          {14'd0, r_full[16], r_ovf, r_full[15:0]});
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised, multi-cycle successor to the team's 1-bit full adder cell.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, one full-adder slice chain of DIGIT bits reused over WIDTH/DIGIT cycles.
- Uses a start/busy/done handshake and reports carry-out and signed overflow.
- Sits in datapaths that trade latency for area where a full WIDTH-bit ripple adder is too large.

## Interface
Parameters:
- WIDTH, default 16: operand and result width; must be ≥ 1.
- DIGIT, default 4: bits processed per cycle. WIDTH % DIGIT == 0 is required; elaboration fails otherwise. N = WIDTH/DIGIT.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- start, input, 1: request a new operation; sampled only when accepting (IDLE or DONE).
- sub, input, 1: 0 = add, 1 = subtract; sampled with start.
- a, input, WIDTH: operand A; sampled with start.
- b, input, WIDTH: operand B; sampled with start.
- cin, input, 1: carry-in for add, sampled with start; ignored when sub=1.
- busy, output, 1: high while digits are being processed.
- done, output, 1: one-cycle pulse; the result is valid.
- sum, output, WIDTH: result, held from done until the next accepted start.
- cout, output, 1: carry out of bit WIDTH-1. For subtract, 1 = no borrow.
- ovf, output, 1: signed overflow = carry into bit WIDTH-1 XOR cout.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 → latch A=a, B=(sub ? ~b : b), carry=(sub ? 1 : cin); clear digit counter and sum register; go to RUN.
- RUN:
  - busy=1. Each cycle, digit k (bits k*DIGIT..k*DIGIT+DIGIT-1) of A and B is added with the carry register through a DIGIT-bit ripple chain.
  - The digit result is written into sum bits of digit k, and carry is updated.
  - On the last digit (k = N-1), capture the carry into bit WIDTH-1 for ovf, set cout, and go to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - start=1 → accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- start while in RUN is ignored; no queuing.
- a, b, sub and cin may change freely after the accepting edge.
- sum, cout and ovf are not updated mid-operation until the digit is written; they are defined only from done onward.
- Latched operands are not visible at outputs.
- DIGIT == WIDTH: N=1, a single RUN cycle.
- DIGIT == 1: pure bit-serial, N=WIDTH RUN cycles.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0.
- rst has priority over every other input. rst asserted mid-RUN aborts the operation; outputs return to reset values on the next edge.
- Start accepted at edge T:
  - busy=1 for cycles T+1..T+N.
  - done=1 in cycle T+N+1, with sum/cout/ovf valid from that cycle.
- Throughput: one result per N+1 cycles with start held high continuously.
- Digit counter width: ceil(log2(N)), min 1. It wraps only via reset to 0 on acceptance.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
WIDTH=16, DIGIT=4 unless stated.
- Add with carry-in: a=0x1234, b=0x0FCD, cin=1, sub=0 → sum=0x2202, cout=0, ovf=0. busy high 4 cycles, then done pulse one cycle.
- Unsigned wrap and signed overflow:
  - 0xFFFF+0x0001 → sum 0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 → sum 0x8000, cout=0, ovf=1.
- Subtract:
  - 0x0005-0x0007 with cin=1 (must be ignored) → sum 0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 → sum 0x7FFF, cout=1, ovf=1.
- Handshake:
  - start pulsed during RUN with different operands → ignored, the first result is unchanged.
  - start held high → results every 5 cycles, done never high two consecutive cycles.
- rst asserted in the 2nd RUN cycle → next cycle busy=0, done=0, sum=0. A fresh start then completes correctly.
- Parameter sweep: DIGIT=1 (16 RUN cycles) and DIGIT=16 (1 RUN cycle), 1000 random a/b/sub/cin each. Sum/cout/ovf must match a reference model.
